// File: rtl/popcount_binarize_pkg.sv
// Shared widths, FSM encoding and saturation limit for the popcount binarise stage.
package popcount_binarize_pkg;
  localparam int PW   = 7;
  localparam int ACCW = 12;
  localparam int NOUT = 112;
  localparam int IDXW = 7;

  localparam logic [0:0] ST_ACC  = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  localparam logic [ACCW-1:0] ACC_MAX = {ACCW{1'b1}};
endpackage

// File: rtl/popcount_binarize_sat_acc.sv
// Saturating accumulate of one popcount beat plus threshold compare; purely combinational.
module popcount_sat_acc
  import popcount_binarize_pkg::*;
(
  input  logic [ACCW-1:0] acc,
  input  logic [PW-1:0]   idata,
  input  logic            first,
  input  logic [ACCW-1:0] thresh,
  input  logic            inv,
  output logic [ACCW-1:0] sum_next,
  output logic            act_bit
);
  logic [ACCW-1:0] base;
  logic [ACCW:0]   sum_w;

  always_comb begin
    base     = first ? {ACCW{1'b0}} : acc;
    sum_w    = {1'b0, base} + {{(ACCW+1-PW){1'b0}}, idata};
    // Carry out of the accumulator width means the true sum exceeds ACC_MAX.
    sum_next = sum_w[ACCW] ? ACC_MAX : sum_w[ACCW-1:0];
    act_bit  = (sum_next >= thresh) ^ inv;
  end
endmodule

// File: rtl/popcount_binarize.sv
// Accumulates popcount beats per neuron, binarises against a threshold and packs
// NOUT activation bits into a word offered on a valid/ready port; stalls upstream while held.
module popcount_binarize
  import popcount_binarize_pkg::*;
(
  input  logic            iCLK,
  input  logic            iRST,
  input  logic            iEN,
  input  logic [PW-1:0]   idata,
  input  logic            iFIRST,
  input  logic            iLAST,
  input  logic [ACCW-1:0] ithresh,
  input  logic            iinv,
  input  logic            iFLUSH,
  input  logic            iREADY,
  output logic [NOUT-1:0] oDATA,
  output logic            oVALID,
  output logic            oSTALL,
  output logic            oERR
);
  logic [0:0]      state_q, state_d;
  logic [ACCW-1:0] acc_q, acc_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [NOUT-1:0] word_q, word_d;
  logic [NOUT-1:0] data_q, data_d;
  logic            valid_q, valid_d;
  logic            err_q, err_d;

  logic [ACCW-1:0] sum_next;
  logic            act_bit;
  logic [NOUT-1:0] word_w;
  logic            bit_wr;
  logic            emit;

  popcount_sat_acc u_sat_acc (
    .acc      (acc_q),
    .idata    (idata),
    .first    (iFIRST),
    .thresh   (ithresh),
    .inv      (iinv),
    .sum_next (sum_next),
    .act_bit  (act_bit)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    word_d  = word_q;
    data_d  = data_q;
    valid_d = valid_q;
    err_d   = err_q;
    word_w  = word_q;
    bit_wr  = 1'b0;
    emit    = 1'b0;

    if (state_q == ST_ACC) begin
      if (iEN) begin
        acc_d = sum_next;
        if (iLAST) begin
          bit_wr         = 1'b1;
          word_w[idx_q]  = act_bit;
          word_d         = word_w;
          acc_d          = {ACCW{1'b0}};
          idx_d          = idx_q + IDXW'(1);
        end
      end
      // A flush counts a bit written in the same cycle, so an idx of 0 plus a new bit still emits.
      emit = (bit_wr && (idx_q == IDXW'(NOUT-1))) ||
             (iFLUSH && (bit_wr || (idx_q != {IDXW{1'b0}})));
      if (emit) begin
        data_d  = word_w;
        valid_d = 1'b1;
        idx_d   = {IDXW{1'b0}};
        word_d  = {NOUT{1'b0}};
        state_d = ST_HOLD;
      end
    end else begin
      if (iEN) begin
        err_d = 1'b1;
      end
      if (iREADY) begin
        valid_d = 1'b0;
        state_d = ST_ACC;
      end
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q <= ST_ACC;
      acc_q   <= {ACCW{1'b0}};
      idx_q   <= {IDXW{1'b0}};
      word_q  <= {NOUT{1'b0}};
      data_q  <= {NOUT{1'b0}};
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign oDATA  = data_q;
  assign oVALID = valid_q;
  assign oSTALL = (state_q == ST_HOLD);
  assign oERR   = err_q;
endmodule

// File: tb/tb_popcount_binarize.sv
// Scoreboard bench: driver updates a reference model and queues expected words; monitor checks outputs.
module tb_popcount_binarize;
  logic         iCLK = 1'b0;
  logic         iRST;
  logic         iEN;
  logic [6:0]   idata;
  logic         iFIRST;
  logic         iLAST;
  logic [11:0]  ithresh;
  logic         iinv;
  logic         iFLUSH;
  logic         iREADY;
  logic [111:0] oDATA;
  logic         oVALID;
  logic         oSTALL;
  logic         oERR;

  always #5 iCLK = ~iCLK;

  popcount_binarize dut (
    .iCLK    (iCLK),
    .iRST    (iRST),
    .iEN     (iEN),
    .idata   (idata),
    .iFIRST  (iFIRST),
    .iLAST   (iLAST),
    .ithresh (ithresh),
    .iinv    (iinv),
    .iFLUSH  (iFLUSH),
    .iREADY  (iREADY),
    .oDATA   (oDATA),
    .oVALID  (oVALID),
    .oSTALL  (oSTALL),
    .oERR    (oERR)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [111:0] exp_q[$];
  int           m_acc   = 0;
  int           m_idx   = 0;
  logic [111:0] m_word  = '0;
  bit           m_hold  = 0;
  logic         exp_err = 1'b0;

  task automatic chk(input string name, input logic [111:0] act, input logic [111:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock of stimulus; the model follows the behavioural rules of the stage.
  task automatic beat(input logic en, input int d, input logic f, input logic l,
                      input int thr, input logic inv, input logic fl, input logic rdy);
    @(posedge iCLK); #2;
    iEN = en; idata = 7'(d); iFIRST = f; iLAST = l;
    ithresh = 12'(thr); iinv = inv; iFLUSH = fl; iREADY = rdy;
    if (m_hold) begin
      if (en) exp_err = 1'b1;
      if (rdy) m_hold = 0;
    end else begin
      if (en) begin
        int s;
        s = (f ? 0 : m_acc) + d;
        if (s > 4095) s = 4095;
        if (l) begin
          m_word[m_idx] = ((s >= thr) ? 1'b1 : 1'b0) ^ inv;
          m_idx++;
          m_acc = 0;
        end else begin
          m_acc = s;
        end
      end
      if (m_idx == 112 || (fl && m_idx > 0)) begin
        exp_q.push_back(m_word);
        m_word = '0;
        m_idx  = 0;
        m_hold = 1;
      end
    end
  endtask

  task automatic idle(input logic rdy);
    beat(1'b0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, rdy);
  endtask

  task automatic neuron(input int d, input int n, input int thr, input logic inv);
    for (int j = 0; j < n; j++)
      beat(1'b1, d, j == 0, j == n - 1, thr, inv, 1'b0, 1'b0);
  endtask

  task automatic flush();
    beat(1'b0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic expect_word(input string name, input logic [111:0] exp);
    idle(1'b0);
    chk({name, "_data"}, oDATA, exp);
    chk({name, "_valid"}, {111'd0, oVALID}, 112'd1);
    idle(1'b1);
  endtask

  task automatic do_reset();
    @(posedge iCLK); #2;
    iRST = 1'b1; iEN = 1'b0; iFLUSH = 1'b0; iREADY = 1'b0;
    m_acc = 0; m_idx = 0; m_word = '0; m_hold = 0; exp_err = 1'b0;
    #1;
    chk("rst_data", oDATA, '0);
    chk("rst_valid", {111'd0, oVALID}, 112'd0);
    chk("rst_stall", {111'd0, oSTALL}, 112'd0);
    chk("rst_err", {111'd0, oERR}, 112'd0);
    @(posedge iCLK); #2;
    iRST = 1'b0;
  endtask

  // Monitor: pops an expected word on each new oVALID, checks stability and sticky error.
  initial begin
    logic         pv;
    logic [111:0] pd;
    pv = 1'b0;
    pd = '0;
    forever begin
      @(posedge iCLK); #1;
      if (oVALID === 1'b1 && !pv) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_word: got %h expected no word", oDATA);
        end else begin
          chk("word", oDATA, exp_q.pop_front());
        end
      end else if (oVALID === 1'b1 && pv) begin
        chk("data_stable", oDATA, pd);
      end
      chk("err", {111'd0, oERR}, {111'd0, exp_err});
      chk("stall", {111'd0, oSTALL}, {111'd0, oVALID});
      pv = (oVALID === 1'b1);
      pd = oDATA;
    end
  end

  initial begin
    logic [111:0] c;
    iRST = 1'b1; iEN = 1'b0; idata = '0; iFIRST = 1'b0; iLAST = 1'b0;
    ithresh = '0; iinv = 1'b0; iFLUSH = 1'b0; iREADY = 1'b0;
    repeat (2) @(posedge iCLK);
    #1;
    chk("init_data", oDATA, '0);
    chk("init_valid", {111'd0, oVALID}, 112'd0);
    chk("init_err", {111'd0, oERR}, 112'd0);
    @(posedge iCLK); #2;
    iRST = 1'b0;

    // Reset mid-word at idx=5, then the next word must start at bit 0.
    for (int i = 0; i < 5; i++) neuron(112, 1, 0, 1'b0);
    do_reset();
    for (int i = 0; i < 3; i++) neuron(112, 1, 0, 1'b0);
    flush();
    expect_word("after_reset", 112'h7);

    // Single-chunk neurons alternating 60/40 against 56.
    for (int i = 0; i < 112; i++)
      beat(1'b1, (i % 2 == 0) ? 60 : 40, 1'b1, 1'b1, 56, 1'b0, 1'b0, 1'b0);
    c = {56{2'b01}};
    expect_word("alt_5555", c);

    // Multi-chunk threshold edge with and without inversion.
    neuron(100, 3, 300, 1'b0);
    neuron(100, 3, 301, 1'b0);
    neuron(100, 3, 300, 1'b1);
    neuron(100, 3, 301, 1'b1);
    flush();
    expect_word("multi_chunk", 112'h9);

    // Saturation: 40 x 112 clamps to 4095.
    neuron(112, 40, 4095, 1'b0);
    flush();
    expect_word("saturate", 112'h1);

    // Flush after ten set bits, then a flush at idx=0 must not emit.
    for (int i = 0; i < 10; i++) neuron(112, 1, 0, 1'b0);
    flush();
    expect_word("flush_3ff", 112'h3FF);
    flush();
    idle(1'b1);
    idle(1'b1);
    chk("flush_idle_novalid", {111'd0, oVALID}, 112'd0);

    // Flush on the same cycle as the first bit of a word.
    beat(1'b1, 112, 1'b1, 1'b1, 0, 1'b0, 1'b1, 1'b0);
    expect_word("flush_same_cycle", 112'h1);

    // Backpressure: hold the word, drop one beat, then release.
    for (int i = 0; i < 112; i++) neuron(112, 1, 0, 1'b0);
    idle(1'b0);
    idle(1'b0);
    beat(1'b1, 112, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b0);
    c = '1;
    chk("bp_data", oDATA, c);
    chk("bp_stall", {111'd0, oSTALL}, 112'd1);
    chk("bp_err", {111'd0, oERR}, 112'd1);
    idle(1'b1);
    chk("bp_valid_before_drop", {111'd0, oVALID}, 112'd1);
    idle(1'b0);
    chk("bp_valid_dropped", {111'd0, oVALID}, 112'd0);
    neuron(112, 1, 0, 1'b0);
    flush();
    expect_word("bp_beat_not_counted", 112'h1);

    // Randomised traffic with random backpressure and flushes.
    for (int i = 0; i < 3000; i++)
      beat(($urandom_range(0, 99) < 85), $urandom_range(0, 112),
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
           $urandom_range(0, 400), ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 99) < 3), ($urandom_range(0, 1) == 1));
    for (int i = 0; i < 4; i++) idle(1'b1);

    chk("queue_empty", 112'(exp_q.size()), 112'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/popcount_binarize.md
# popcount_binarize

Downstream stage of the XNOR-popcount unit. Accumulates per-beat popcount results into a per-neuron sum, then binarises the sum against a folded batch-norm threshold with optional sign flip. Packs the resulting activation bits into an NOUT-bit word for the next binary layer, with a valid/ready output handshake and a stall indication back to the sequencer.

## Interface
- PW, 7, popcount input width (0..112 per beat)
- ACCW, 12, accumulator / threshold width
- NOUT, 112, activation bits per packed output word
- IDXW, 7, width of bit-index counter (ceil(log2(NOUT)))
- iCLK  in  1  clock, rising edge
- iRST  in  1  reset, asynchronous, active-high
- iEN  in  1  popcount beat valid (driven by popcount oEN)
- idata  in  PW  popcount value for this beat
- iFIRST  in  1  beat is first chunk of a neuron (clears accumulator)
- iLAST  in  1  beat is last chunk of a neuron (triggers binarisation)
- ithresh  in  ACCW  neuron threshold in popcount domain, sampled on iLAST beat
- iinv  in  1  invert decision (negative BN gamma), sampled on iLAST beat
- iFLUSH  in  1  emit partially filled word (end of layer)
- iREADY  in  1  consumer accepts oDATA
- oDATA  out  NOUT  packed activations, bit i = neuron i of word
- oVALID  out  1  oDATA valid
- oSTALL  out  1  word pending and not accepted; upstream must hold iEN low
- oERR  out  1  sticky: beat received while oSTALL high (beat dropped)

## Operation
- States: ACC (collecting bits), HOLD (word complete, awaiting iREADY).
- Accumulate: on iEN, sum_next = (iFIRST ? 0 : acc) + idata, saturating at 2^ACCW-1; acc <= sum_next.
- Binarise on iEN & iLAST: bit = (sum_next >= ithresh) XOR iinv; written to word[idx]; idx increments; acc cleared.
- iFIRST & iLAST on same beat = single-chunk neuron, sum_next = idata.
- Word complete when bit written at idx = NOUT-1: oDATA <= word, oVALID <= 1, idx <= 0, word <= 0, -> HOLD.
- iFLUSH in ACC with idx>0 (after counting any same-cycle bit): emit word, unwritten bits 0, -> HOLD. iFLUSH with idx=0 and no same-cycle bit: ignored.
- HOLD: oVALID=1, oSTALL=1, oDATA stable. iREADY -> oVALID <= 0, -> ACC. Beats in HOLD are dropped, acc/idx unchanged, oERR <= 1.
- oERR cleared only by iRST.
- Reset mid-operation: all state discarded, partial word lost.

## Timing
- Reset values: oDATA=0, oVALID=0, oSTALL=0, oERR=0, acc=0, idx=0, state ACC.
- Accumulation: 1 cycle; bit visible in internal word at edge following iLAST beat.
- oVALID rises at the edge that samples the NOUT-th iLAST beat (or iFLUSH); latency 1 cycle.
- Handshake: transfer on the edge where oVALID & iREADY; earliest next oVALID is the cycle after.
- iREADY while oVALID=0 ignored.
- Back-to-back beats accepted every cycle in ACC; no bubble between neurons.
- oSTALL combinational from state (= HOLD); registered via state, no input-to-output comb path.

## Structure
- Shared package: PW, ACCW, NOUT, IDXW defaults, state encoding (ST_ACC, ST_HOLD), ACC_MAX constant.
- One sub-module: popcount_sat_acc (saturating accumulate-and-compare, outputs sum_next and bit).
- Top holds FSM, idx counter, pack register, output register.

## Test plan
- Reset: assert iRST mid-word (idx=5) -> all outputs 0, next word starts at bit 0.
- Single-chunk neurons: 112 beats iFIRST=iLAST=1, idata alternating 60/40, ithresh=56, iinv=0 -> oVALID after beat 112, oDATA = 0x5555...5 (bit0=1).
- Multi-chunk: neuron of 3 beats 100,100,100, ithresh=300 -> bit=1; ithresh=301 -> bit=0; iinv=1 flips both.
- Saturation: 40 beats idata=112 (ACCW=12) -> acc holds 4095, ithresh=4095 -> bit=1.
- Flush: 10 neurons all bit=1 then iFLUSH -> oDATA = 0x3FF, upper bits 0; iFLUSH at idx=0 -> no oVALID.
- Backpressure: word complete, iREADY=0 for 5 cycles, 1 beat injected -> oDATA stable, oSTALL=1, oERR=1, beat not counted; iREADY=1 -> oVALID drops next cycle.
